// File: rtl/hba_slave_regs.sv
// HBA bus slave register bank for one peripheral slot.
// Decodes master transfers and performs register reads and writes.
// Each transfer gets a single-cycle registered acknowledge. The peripheral
// core sees every register and can overwrite any of them locally.
module hba_slave_regs #(
    parameter logic [3:0]          PERIPH_ADDR = 4'd0,
    parameter int                  NUM_REGS    = 4,
    parameter int                  DBUS_WIDTH  = 8,
    parameter int                  ADDR_WIDTH  = 12,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           hba_clk,
    input  logic                           hba_reset,
    input  logic                           hba_select,
    input  logic                           hba_rnw,
    input  logic [ADDR_WIDTH-1:0]          hba_abus,
    input  logic [DBUS_WIDTH-1:0]          hba_dbus,
    output logic                           slave_xferack,
    output logic [DBUS_WIDTH-1:0]          slave_dbus,
    output logic [DBUS_WIDTH*NUM_REGS-1:0] slv_reg_out,
    input  logic [NUM_REGS-1:0]            slv_wr_en,
    input  logic [DBUS_WIDTH*NUM_REGS-1:0] slv_wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  xferack_q, xferack_d;
    logic [DBUS_WIDTH-1:0] dbus_q, dbus_d;
    logic [DBUS_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DBUS_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  hit;
    logic [7:0]            idx;
    logic [DBUS_WIDTH-1:0] rd_data;
    logic                  bus_wr;
    logic [NUM_REGS-1:0]   bus_wr_en;

    // A hit needs an active select and our slot number in the upper address nibble.
    assign hit    = hba_select && (hba_abus[ADDR_WIDTH-1 -: 4] == PERIPH_ADDR);
    assign idx    = hba_abus[7:0];
    assign bus_wr = (state_q == IDLE) && hit && !hba_rnw;

    // Register mux for reads and per-register bus write strobes.
    // An out-of-range index matches no register, so reads return zero and writes are dropped.
    always_comb begin
        rd_data   = '0;
        bus_wr_en = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 8'(i)) begin
                rd_data      = regs_q[i];
                bus_wr_en[i] = bus_wr && !RO_MASK[i];
            end
        end
    end

    // Register next state: a bus write applies first, and a local core write overrides it.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (bus_wr_en[i]) begin
                regs_d[i] = hba_dbus;
            end
            if (slv_wr_en[i]) begin
                regs_d[i] = slv_wr_data[i*DBUS_WIDTH +: DBUS_WIDTH];
            end
        end
    end

    // Transfer FSM next state and next values of the registered bus outputs.
    always_comb begin
        state_d   = state_q;
        xferack_d = 1'b0;
        dbus_d    = '0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d   = ACK;
                    xferack_d = 1'b1;
                    if (hba_rnw) begin
                        dbus_d = rd_data;
                    end
                end
            end
            ACK: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!hba_select) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and the registered bus outputs; reset also aborts a transfer in flight.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state_q   <= IDLE;
            xferack_q <= 1'b0;
            dbus_q    <= '0;
        end else begin
            state_q   <= state_d;
            xferack_q <= xferack_d;
            dbus_q    <= dbus_d;
        end
    end

    // Register bank storage.
    always_ff @(posedge hba_clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hba_reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign slv_reg_out[g*DBUS_WIDTH +: DBUS_WIDTH] = regs_q[g];
        end
    endgenerate

    assign slave_xferack = xferack_q;
    assign slave_dbus    = dbus_q;

endmodule
